// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package ifetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD} ifetch_state_t;
  localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/ifetch_pcnext.sv
// Next-PC selection for the held instruction: sequential, branch or jump.
module pcnext
  import ifetch_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] pc,
  input  logic [25:0]  instr,
  input  logic         pcsrc,
  input  logic         jump,
  output logic [n-1:0] pcplus4,
  output logic [n-1:0] pcbranch,
  output logic [n-1:0] pcjump,
  output logic [n-1:0] next_pc
);
  assign pcplus4  = pc + n'(4);
  assign pcbranch = pcplus4 + {{(n-18){instr[15]}}, instr[15:0], 2'b00};
  assign pcjump   = {pcplus4[n-1:28], instr[25:0], 2'b00};

  // Jump outranks a taken branch when the controller raises both.
  always_comb begin
    next_pc = pcplus4;
    if (jump)       next_pc = pcjump;
    else if (pcsrc) next_pc = pcbranch;
  end
endmodule

// File: rtl/ifetch.sv
// Fetch stage: owns the PC, handshakes with instruction memory and holds
// the fetched word until the downstream stage accepts it.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = IFETCH_RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [n-1:0] imem_rdata,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [n-1:0] instr,
  output logic [5:0]   op,
  output logic [5:0]   funct,
  output logic [n-1:0] pc,
  output logic [n-1:0] pcplus4,
  input  logic         pcsrc,
  input  logic         jump,
  output logic [31:0]  retired
);
  ifetch_state_t state, state_next;
  logic          capture, accept;
  logic [n-1:0]  next_pc, branch_target, jump_target;
  logic          unused_targets;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    capture     = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_req = 1'b1;
        capture  = imem_ready;
        if (imem_ready) state_next = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        accept      = instr_ready;
        if (instr_ready) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
    end else begin
      if (capture) instr <= imem_rdata;
      if (accept) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

  pcnext #(.n(n)) u_pcnext (
    .pc       (pc),
    .instr    (instr[25:0]),
    .pcsrc    (pcsrc),
    .jump     (jump),
    .pcplus4  (pcplus4),
    .pcbranch (branch_target),
    .pcjump   (jump_target),
    .next_pc  (next_pc)
  );

  // Individual targets are only observed for debug; selection uses next_pc.
  assign unused_targets = ^{branch_target, jump_target};

  assign imem_addr = pc;
  assign op        = instr[31:26];
  assign funct     = instr[5:0];
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus randomized traffic against a
// transaction-level reference model checked every cycle.
module tb_ifetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready, instr_valid, instr_ready, pcsrc, jump;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pcplus4, retired;
  logic [5:0]  op, funct;

  int checks = 0;
  int failures = 0;

  ifetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .op(op), .funct(funct), .pc(pc),
    .pcplus4(pcplus4), .pcsrc(pcsrc), .jump(jump), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one dead cycle after reset, then request until memory
  // answers, then hold until accepted, then move PC and request again.
  logic [31:0] m_pc, m_instr, m_ret;
  logic        m_idle, m_req, m_valid;

  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] ins,
                                            input logic ps, input logic jp);
    logic [31:0] p4;
    int off;
    p4 = p + 32'd4;
    if (jp) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    off = int'($signed(ins[15:0]));
    if (ps) return p4 + 32'(off * 4);
    return p4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_ret = 32'h0;
      m_idle = 1'b1; m_req = 1'b0; m_valid = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0; m_req = 1'b1;
    end else if (m_req) begin
      if (imem_ready) begin
        m_instr = imem_rdata; m_req = 1'b0; m_valid = 1'b1;
      end
    end else if (m_valid && instr_ready) begin
      m_pc = model_npc(m_pc, m_instr, pcsrc, jump);
      m_ret = m_ret + 32'd1;
      m_valid = 1'b0; m_req = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("m_imem_req", 32'(imem_req), 32'(m_req));
    chk("m_instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_pc", pc, m_pc);
    chk("m_pcplus4", pcplus4, m_pc + 32'd4);
    chk("m_instr", instr, m_instr);
    chk("m_op", 32'(op), m_instr >> 26);
    chk("m_funct", 32'(funct), m_instr & 32'h3F);
    chk("m_retired", retired, m_ret);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve one fetch at exp_pc with `waits` wait cycles, stall `stall` cycles
  // in HOLD with noisy pcsrc/jump, then accept with the given decisions.
  task automatic fetch(input logic [31:0] word, input int waits, input int stall,
                       input logic ps, input logic jp, input logic [31:0] exp_pc);
    int k = 0;
    while (!imem_req && k < 20) begin step(); k++; end
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ready = 1'b0;
    repeat (waits) step();
    imem_ready = 1'b1; imem_rdata = word;
    step();
    imem_ready = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    chk("hold_instr", instr, word);
    pcsrc = 1'b1; jump = 1'b1;
    repeat (stall) begin
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_pc", pc, exp_pc);
      step();
    end
    chk("stall_instr", instr, word);
    instr_ready = 1'b1; pcsrc = ps; jump = jp;
    step();
    instr_ready = 1'b0; pcsrc = 1'b0; jump = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, 32'h0);
    reset = 1'b0;

    // Zero-wait first fetch with instr_ready held high.
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005; instr_ready = 1'b1;
    chk("c1_req", 32'(imem_req), 32'd0);
    step();
    chk("c2_req", 32'(imem_req), 32'd1);
    chk("c2_addr", imem_addr, 32'h0);
    step();
    imem_ready = 1'b0;
    chk("c3_valid", 32'(instr_valid), 32'd1);
    chk("c3_op", 32'(op), 32'h08);
    chk("c3_instr", instr, 32'h2008_0005);
    step();
    instr_ready = 1'b0;
    chk("c4_addr", imem_addr, 32'h4);
    chk("c4_retired", retired, 32'd1);

    // Three wait cycles at 0x4; capture only on the ready edge.
    for (int i = 0; i < 4; i++) begin
      chk("wait_addr", imem_addr, 32'h4);
      chk("wait_instr", instr, 32'h2008_0005);
      if (i == 3) begin imem_ready = 1'b1; imem_rdata = 32'h0800_0004; end
      else imem_rdata = 32'hFFFF_FFFF;
      step();
    end
    imem_ready = 1'b0;
    chk("wait_capt", instr, 32'h0800_0004);
    instr_ready = 1'b1; jump = 1'b1;
    step();
    instr_ready = 1'b0; jump = 1'b0;
    chk("j_0x10", pc, 32'h10);

    // Branch back to self, then fall through; 5-cycle stall on the first.
    fetch(32'h1000_FFFF, 1, 5, 1'b1, 1'b0, 32'h10);
    chk("br_self", pc, 32'h10);
    fetch(32'h1000_FFFF, 0, 0, 1'b0, 1'b0, 32'h10);
    chk("br_fall", pc, 32'h14);
    chk("ret_4", retired, 32'd4);

    // Walk the PC across 256MB regions with jumps, then jump priority.
    fetch(32'h0BFF_FFFF, 2, 0, 1'b0, 1'b1, 32'h14);
    chk("j_a", pc, 32'h0FFF_FFFC);
    fetch(32'h0800_0000, 0, 1, 1'b0, 1'b1, 32'h0FFF_FFFC);
    chk("j_b", pc, 32'h1000_0000);
    fetch(32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1, 32'h1000_0000);
    chk("j_c", pc, 32'h1FFF_FFFC);
    fetch(32'h0800_0000, 0, 0, 1'b0, 1'b1, 32'h1FFF_FFFC);
    chk("j_d", pc, 32'h2000_0000);
    fetch(32'h0800_0040, 1, 0, 1'b1, 1'b1, 32'h2000_0000);
    chk("j_prio", pc, 32'h2000_0100);
    chk("ret_9", retired, 32'd9);

    // Reset mid-REQ, then a late ready pulse that must be ignored.
    #2 reset = 1'b1;
    #1;
    chk("mr_req", 32'(imem_req), 32'd0);
    chk("mr_pc", pc, 32'h0);
    chk("mr_instr", instr, 32'h0);
    chk("mr_ret", retired, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    chk("mr_idle", 32'(imem_req), 32'd0);
    step();
    imem_ready = 1'b0;
    chk("mr_req2", 32'(imem_req), 32'd1);
    chk("mr_ign", instr, 32'h0);
    step();
    chk("mr_stay", 32'(instr_valid), 32'd0);
    fetch(32'h2008_0005, 1, 0, 1'b0, 1'b0, 32'h0);
    chk("mr_pc4", pc, 32'h4);

    // Randomized traffic, including occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      imem_ready  = ($urandom_range(0, 2) == 0);
      imem_rdata  = $urandom;
      instr_ready = ($urandom_range(0, 3) != 0);
      pcsrc       = $urandom_range(0, 1) == 1;
      jump        = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch.md
# ifetch

Sequential instruction-fetch stage for the 32-bit MIPS CPU, sitting directly upstream of the controller/datapath. It owns the program counter, runs a request/ready handshake with a variable-latency instruction memory, holds the fetched word in an instruction register, and presents `op`/`funct` to the controller. It consumes the controller's `pcsrc` and `jump` decisions to select the next PC when the downstream stage accepts the instruction.

## Interface
- `n`, 32: data/address width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  n  word-aligned fetch address, equal to `pc`.
- `imem_ready`  in  1  memory has valid data on `imem_rdata` this cycle.
- `imem_rdata`  in  n  fetched instruction word.
- `instr_valid`  out  1  instruction register holds an instruction for execution.
- `instr_ready`  in  1  downstream accepts/executes the held instruction this cycle.
- `instr`  out  n  instruction register.
- `op`  out  6  `instr[31:26]`, to controller.
- `funct`  out  6  `instr[5:0]`, to controller.
- `pc`  out  n  address of the held instruction.
- `pcplus4`  out  n  `pc + 4`.
- `pcsrc`  in  1  controller: taken branch for the held instruction.
- `jump`  in  1  controller: jump for the held instruction.
- `retired`  out  32  count of accepted instructions.

## Operation
- FSM states: IDLE, REQ, HOLD.
- Reset (async): state=IDLE, `pc`=RESET_PC, `instr`=0, `retired`=0; outputs `imem_req`=0, `instr_valid`=0.
- IDLE: one cycle, no request; next state REQ.
- REQ: `imem_req`=1, `imem_addr`=`pc` stable; on an edge with `imem_ready`=1, `instr`<=`imem_rdata`, next state HOLD; otherwise stay in REQ.
- HOLD: `instr_valid`=1; `instr` and `pc` frozen. On an edge with `instr_ready`=1: `pc`<=next PC, `retired`<=`retired`+1, next state REQ.
- Next PC, evaluated in HOLD from the held `instr`:
  - `jump`: `{pcplus4[31:28], instr[25:0], 2'b00}`.
  - else `pcsrc`: `pcplus4 + (signext(instr[15:0]) << 2)`, modulo 2^n.
  - else `pcplus4`.
- `jump` and `pcsrc` both high: jump wins.
- `imem_ready` in IDLE or HOLD is ignored. `pcsrc`/`jump` outside HOLD-with-`instr_ready` are ignored.
- `pc` wraps modulo 2^n. `retired` wraps 0xFFFF_FFFF -> 0.
- Reset during REQ: request drops asynchronously. A late `imem_ready` after reset is ignored because the FSM is in IDLE.

## Timing
- `op`, `funct`, `pcplus4` and `imem_addr` are combinational from registers. No input-to-output combinational path except next-PC logic, which feeds registers only.
- Zero-wait memory (`imem_ready` high in the first REQ cycle) with `instr_ready` held high: 2 cycles per instruction, alternating REQ and HOLD.
- Memory with k wait cycles adds k cycles in REQ.
- After reset deassertion: first `imem_req` in cycle 2; earliest `instr_valid` in cycle 3.
- `instr_valid` never drops without acceptance unless reset is asserted.

## Structure
- Package `ifetch_pkg`: state enum typedef `ifetch_state_t` {IDLE, REQ, HOLD} and default constant `IFETCH_RESET_PC`.
- Sub-module `pcnext`, combinational, outputs next PC.
  - Inputs: `pc`, `instr`, `pcsrc`, `jump`.
  - Outputs: `pcplus4`, branch target, jump target, selected next PC.
- Top-level holds the FSM, `pc`, `instr` and `retired` registers.

## Test plan
- Reset then zero-wait memory returning 32'h2008_0005 at 0x0, `instr_ready`=1 -> `imem_req` first in cycle 2; `instr_valid` with `op`=6'h08 in cycle 3; next request addr 0x4; `retired`=1.
- Memory with 3 wait cycles at 0x4 -> `imem_addr` stays 0x4 for 4 cycles; instruction is captured only on the `imem_ready` edge.
- HOLD at `pc`=0x10 with `instr`=32'h1000_FFFF, `pcsrc`=1 -> next `pc`=0x10. With `pcsrc`=0 -> next `pc`=0x14.
- HOLD at `pc`=0x2000_0000 with `instr`=32'h0800_0040, `jump`=1, `pcsrc`=1 -> next `pc`=0x2000_0100 (jump priority).
- `instr_ready`=0 for 5 cycles in HOLD -> `instr`, `pc`, `instr_valid` stable, no `imem_req`, `retired` unchanged.
- Assert `reset` mid-REQ, then pulse `imem_ready` one cycle later -> `imem_req`=0 immediately; `pc`=RESET_PC; `instr`=0; the pulse is ignored; fetch restarts at RESET_PC.
